// File: rtl/bus_ram_responder_if.sv
// Core-to-responder data-bus bundle: REQ/GNT handshake, region select,
// byte/halfword/word access fields and the OR-combinable response.
interface bus_ram_responder_if;
  logic        req;
  logic [7:0]  ce;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        re;
  logic [1:0]  hb;
  logic [31:0] rdata;
  logic        gnt;
  logic        misalign;

  modport master (
    output req, ce, addr, wdata, we, re, hb,
    input  rdata, gnt, misalign
  );

  modport slave (
    input  req, ce, addr, wdata, we, re, hb,
    output rdata, gnt, misalign
  );
endinterface

// File: rtl/bus_ram_responder.sv
// Wait-stated single-port RAM responder on the core data bus with byte/halfword/word lanes.
// Define BUS_RAM_MISALIGN_EN to flag and suppress misaligned accesses instead of force-aligning them.
module bus_ram_responder #(
  parameter int CE_INDEX    = 0,
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic                clk,
  input  logic                rst,
  bus_ram_responder_if.slave  bus
);
  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  function automatic logic [1:0] align_lane(input logic [1:0] hb, input logic [1:0] lane);
    case (hb)
      2'b00:   return lane;
      2'b01:   return {lane[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] hb, input logic [1:0] lane);
    case (hb)
      2'b00:   return 4'b0001 << lane;
      2'b01:   return 4'b0011 << lane;
      default: return 4'b1111;
    endcase
  endfunction

  // Narrow stores are replicated across the word so the byte enables alone pick the lanes.
  function automatic logic [31:0] replicate(input logic [31:0] wdata, input logic [1:0] hb);
    case (hb)
      2'b00:   return {4{wdata[7:0]}};
      2'b01:   return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] hb,
                                          input logic [1:0] lane);
    logic [31:0] shifted;
    shifted = word >> {lane, 3'b000};
    case (hb)
      2'b00:   return {24'd0, shifted[7:0]};
      2'b01:   return {16'd0, shifted[15:0]};
      default: return shifted;
    endcase
  endfunction

  logic [31:0]       mem [DEPTH];
  state_t            state;
  logic [3:0]        cnt;
  logic              gnt_p1;
  logic              mis_p1;
  logic [31:0]       rdata_p1;

  logic              sel;
  logic              access;
  logic              mis;
  logic              wr_en;
  logic [ADDR_W-1:0] idx;
  logic [1:0]        raw_lane;
  logic [1:0]        lane;
  logic [3:0]        be;
  logic [31:0]       wrep;
  logic [31:0]       word;
  logic [31:0]       rd_result;
  logic              unused_bits;

  assign sel      = bus.req & bus.ce[CE_INDEX] & (bus.we | bus.re);
  assign idx      = bus.addr[ADDR_W+1:2];
  assign raw_lane = bus.addr[1:0];
  assign lane     = align_lane(bus.hb, raw_lane);
  assign be       = byte_en(bus.hb, lane);
  assign wrep     = replicate(bus.wdata, bus.hb);
  assign word     = mem[idx];

`ifdef BUS_RAM_MISALIGN_EN
  assign mis = ((bus.hb == 2'b01) && raw_lane[0]) || (bus.hb[1] && (raw_lane != 2'b00));
`else
  assign mis = 1'b0;
`endif

  assign rd_result = (bus.we || mis) ? 32'd0 : extract(word, bus.hb, lane);
  assign access    = ~rst & sel &
                     (((state == IDLE) && (WAIT_STATES == 0)) || ((state == WAIT) && (cnt == 4'd0)));
  assign wr_en     = access & bus.we & ~mis;

  assign unused_bits = ^{bus.addr[31:ADDR_W+2], bus.ce};

  // Access edge: RAM write with lane enables; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wrep[8*b +: 8];
      end
    end
  end

  // Handshake FSM; response registers are zero outside the single ACK cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      gnt_p1   <= 1'b0;
      mis_p1   <= 1'b0;
      rdata_p1 <= 32'd0;
    end else begin
      gnt_p1   <= 1'b0;
      mis_p1   <= 1'b0;
      rdata_p1 <= 32'd0;
      case (state)
        IDLE: begin
          if (sel) begin
            if (WAIT_STATES == 0) begin
              state    <= ACK;
              gnt_p1   <= 1'b1;
              mis_p1   <= mis;
              rdata_p1 <= rd_result;
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (!sel) begin
            state <= IDLE;
            cnt   <= 4'd0;
          end else if (cnt == 4'd0) begin
            state    <= ACK;
            gnt_p1   <= 1'b1;
            mis_p1   <= mis;
            rdata_p1 <= rd_result;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt      = gnt_p1;
  assign bus.rdata    = rdata_p1;
  assign bus.misalign = mis_p1;
endmodule

// File: doc/bus_ram_responder.md
# bus_ram_responder

Data-bus responder serving the core's load/store requests to one chip-enable region. It sits on the shared data bus beside other responders. It holds a byte-addressable single-port RAM, inserts a configurable number of wait states, and returns a one-cycle grant that releases the core's decode stall. It is the target side of the core's REQ/GNT handshake, with byte, halfword and word lane handling.

## Interface
- CE_INDEX, 0 — bit of i_BUS_CE this responder answers to (0..7).
- ADDR_W, 10 — word-address width; RAM is 2^ADDR_W x 32 bits (default 4 KiB).
- WAIT_STATES, 1 — extra cycles between request acceptance and grant (0..15).
- i_CLK  in  1  — clock, all state on rising edge.
- i_RST  in  1  — reset: one clock; reset is synchronous and active-high.
- i_BUS_REQ  in  1  — core request, held until grant.
- i_BUS_CE  in  8  — one-hot region select.
- i_BUS_ADDR  in  32  — byte address; bits [ADDR_W+1:0] used.
- i_BUS_WDATA  in  32  — write data, right-justified.
- i_BUS_WE  in  1  — write request.
- i_BUS_RE  in  1  — read request.
- i_BUS_HB  in  2  — size: 00 byte, 01 halfword, 10 word, 11 treated as word.
- o_BUS_RDATA  out  32  — read data, right-justified, zero-extended; 0 whenever o_BUS_GNT is low (OR-combinable).
- o_BUS_GNT  out  1  — one-cycle grant pulse (OR-combined at top level).
- o_MISALIGN  out  1  — misaligned-access flag, coincident with grant (tied 0 without macro).

## Operation
- Selected request: i_BUS_REQ & i_BUS_CE[CE_INDEX] & (i_BUS_WE | i_BUS_RE).
- FSM states: IDLE, WAIT, ACK.
  - IDLE -> WAIT on a selected request, with cnt loaded to WAIT_STATES-1. If WAIT_STATES=0, IDLE -> ACK directly and the access is performed.
  - WAIT: cnt decrements each cycle. When cnt==0, the access is performed and the state moves to ACK.
  - ACK: o_BUS_GNT=1 with registered read data. Always returns to IDLE.
- Abort: if the request deasserts (REQ low or CE bit low) in WAIT, return to IDLE. No write and no grant.
- Address decode: the word index is ADDR[ADDR_W+1:2] and the lane is ADDR[1:0]. Upper address bits are ignored (aliasing).
- Write: byte enables follow size and lane.
  - Byte: WDATA[7:0] is written to lane ADDR[1:0].
  - Halfword: WDATA[15:0] is written to lanes {ADDR[1],0}+1..0.
  - Word: all four lanes are written.
- Read: the selected lane is shifted down to bit 0 and the upper bits are zeroed. Sign extension is the core's job.
- WE and RE both high: treated as a write, and o_BUS_RDATA=0 at grant.
- Inputs are sampled at the access edge. Changes to ADDR/WDATA before grant are not tracked: the core holds them stable, and stability is not checked.
- RAM contents are not cleared by reset.

## Timing
- Reset values: state IDLE, o_BUS_GNT=0, o_BUS_RDATA=0, o_MISALIGN=0, cnt=0.
- Latency: a request sampled at edge E0 produces a grant high during the cycle after edge E0+WAIT_STATES, i.e. WAIT_STATES+1 cycles of stall.
- Grant is exactly one cycle. The core samples it at the end of that cycle and drops or updates REQ at the same edge.
- Back-to-back: the earliest next acceptance is the edge ending the IDLE cycle after ACK. Throughput is one access per WAIT_STATES+2 cycles.
- Reset asserted in any state forces IDLE on the next edge and drops grant. An in-flight write that has not reached its access edge is discarded.
- Requests with a non-matching CE are ignored. The outputs stay 0.

## Configuration
- BUS_RAM_MISALIGN_EN defined:
  - A halfword with ADDR[0]=1, or a word with ADDR[1:0]!=0, is misaligned.
  - A misaligned write is suppressed and a misaligned read returns 0.
  - The grant is still issued, with o_MISALIGN=1 for the same cycle.
- Undefined: low address bits are forced to alignment.
  - Halfword ignores ADDR[0]; word ignores ADDR[1:0].
  - The access proceeds normally and o_MISALIGN is constant 0.

## Test plan
- Word write/read: WAIT_STATES=1, CE_INDEX=2, CE=8'h04.
  - Write 0xDEADBEEF to 0x10 -> GNT 2 cycles after acceptance.
  - Read 0x10 -> RDATA=0xDEADBEEF with GNT, RDATA=0 in the next cycle.
- Byte/halfword lanes: word 0x10 preset to 0xDEADBEEF.
  - Byte-write 0x5A to 0x12 -> word reads 0xDE5ABEEF.
  - Halfword read of 0x12 -> 0x0000DE5A.
  - Byte read of 0x13 -> 0x000000DE.
- Zero wait: WAIT_STATES=0.
  - Read -> GNT in the cycle after acceptance.
  - Two back-to-back requests -> grants 2 cycles apart.
- Abort and deselect:
  - Drop REQ in WAIT during a write of 0x11111111 -> no GNT, memory unchanged.
  - CE=8'h01 with CE_INDEX=2 -> no GNT ever.
- Misaligned (with BUS_RAM_MISALIGN_EN):
  - Word write to 0x11 -> GNT=1, o_MISALIGN=1, memory unchanged.
  - Without the macro -> the same write lands at 0x10.
- Reset mid-wait: WAIT_STATES=4, assert i_RST on cycle 2 of a write -> GNT never pulses, state IDLE, target word unchanged.
